pc_unit: RTL and testbench

- Next-generation program counter for the RV32 fetch stage.
- Selects the next fetch address from these sources, by fixed priority:
  - trap vector
  - exception return
  - resolved branch/jump redirect
  - stall hold
  - return-address-stack (RAS) prediction
  - sequential step
- Supports 16-bit compressed steps (+2), reports misaligned redirect targets, and keeps a parametrised circular RAS for call/return prediction.
- Sits between the fetch address mux and instruction memory; the decode, execute and CSR stages drive it.

---
 rtl/pc_unit.sv | 140 ++++++++++++++
 tb/tb_pc_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit -- RV32 fetch-stage program counter with a circular return-address stack.
//
// The next fetch address comes from one of these sources, highest priority first:
// trap vector, mret target, resolved redirect, stall hold, RAS prediction on a
// return, sequential step. Steps are +2 for compressed instructions when C_EXT_P
// is set, otherwise +4. A misaligned redirect target holds the PC and raises
// misalign_o so that the CSR stage can trap on a later cycle.
//
// Ports:
//   clk_i, rst_i          clock and synchronous active-high reset
//   stall_i               hold the PC
//   trap_i, trap_vec_i    take trap to trap_vec_i (word aligned)
//   mret_i, mepc_i        return from trap to mepc_i
//   redirect_i, redirect_addr_i  resolved branch/jump target
//   compressed_i          instruction at pc_q_o is 16-bit
//   call_i, ret_i         instruction at pc_q_o is a call / return
//   pc_q_o                current PC
//   pc_seq_o              pc_q_o + step (link address)
//   misalign_o            redirect target misaligned (combinational)
//   ras_empty_o, ras_full_o  RAS occupancy flags (registered state only)
module pc_unit #(
  parameter int          WIDTH_P      = 32,
  parameter logic [31:0] RESET_ADDR_P = 32'h0000_0000,
  parameter int          C_EXT_P      = 1,
  parameter int          RAS_DEPTH_P  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               trap_i,
  input  logic [WIDTH_P-1:0] trap_vec_i,
  input  logic               mret_i,
  input  logic [WIDTH_P-1:0] mepc_i,
  input  logic               redirect_i,
  input  logic [WIDTH_P-1:0] redirect_addr_i,
  input  logic               compressed_i,
  input  logic               call_i,
  input  logic               ret_i,
  output logic [WIDTH_P-1:0] pc_q_o,
  output logic [WIDTH_P-1:0] pc_seq_o,
  output logic               misalign_o,
  output logic               ras_empty_o,
  output logic               ras_full_o
);

  localparam int                 PTR_W      = (RAS_DEPTH_P > 1) ? $clog2(RAS_DEPTH_P) : 1;
  localparam logic [PTR_W:0]     DEPTH_C    = (PTR_W+1)'(RAS_DEPTH_P);
  localparam logic [WIDTH_P-1:0] RESET_PC_C = WIDTH_P'(RESET_ADDR_P);

  function automatic logic is_misaligned(input logic [WIDTH_P-1:0] addr);
    if (C_EXT_P != 0) return addr[0];
    return addr[1] | addr[0];
  endfunction

  function automatic logic [WIDTH_P-1:0] align_trap(input logic [WIDTH_P-1:0] addr);
    return {addr[WIDTH_P-1:2], 2'b00};
  endfunction

  function automatic logic [WIDTH_P-1:0] align_mret(input logic [WIDTH_P-1:0] addr);
    if (C_EXT_P != 0) return {addr[WIDTH_P-1:1], 1'b0};
    return {addr[WIDTH_P-1:2], 2'b00};
  endfunction

  logic [WIDTH_P-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W:0]     cnt_q, cnt_d;
  logic [WIDTH_P-1:0] ras_q [RAS_DEPTH_P];
  logic [WIDTH_P-1:0] ras_d [RAS_DEPTH_P];

  logic [WIDTH_P-1:0] step;
  logic [WIDTH_P-1:0] pc_seq;
  logic [PTR_W-1:0]   ptr_inc;
  logic               redir_mis;
  logic               ras_en;
  logic               ras_nonempty;

  // Combinational next-PC and RAS update
  always_comb begin
    step         = ((C_EXT_P != 0) && compressed_i) ? WIDTH_P'(2) : WIDTH_P'(4);
    pc_seq       = pc_q + step;
    ptr_inc      = ptr_q + 1'b1;
    redir_mis    = is_misaligned(redirect_addr_i);
    ras_nonempty = (cnt_q != '0);
    ras_en       = !trap_i && !mret_i && !redirect_i && !stall_i;

    if (trap_i) begin
      pc_d = align_trap(trap_vec_i);
    end else if (mret_i) begin
      pc_d = align_mret(mepc_i);
    end else if (redirect_i) begin
      pc_d = redir_mis ? pc_q : redirect_addr_i;
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (ret_i && ras_nonempty) begin
      pc_d = ras_q[ptr_q];
    end else begin
      pc_d = pc_seq;
    end

    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ras_d = ras_q;
    if (ras_en) begin
      if (call_i && ret_i && ras_nonempty) begin
        // Tail call: the popped slot is reused for the new link address.
        ras_d[ptr_q] = pc_seq;
      end else if (call_i) begin
        // Covers call+ret on an empty stack too: behaves as a plain push.
        ptr_d          = ptr_inc;
        ras_d[ptr_inc] = pc_seq;
        cnt_d          = (cnt_q == DEPTH_C) ? cnt_q : cnt_q + 1'b1;
      end else if (ret_i && ras_nonempty) begin
        ptr_d = ptr_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Registered state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q  <= RESET_PC_C;
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH_P; i++) ras_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ras_q <= ras_d;
    end
  end

  assign pc_q_o      = pc_q;
  assign pc_seq_o    = pc_seq;
  assign misalign_o  = !rst_i && redirect_i && !trap_i && !mret_i && redir_mis;
  assign ras_empty_o = (cnt_q == '0);
  assign ras_full_o  = (cnt_q == DEPTH_C);

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: a compressed-enabled instance driven by a table of
// per-cycle vectors, plus a 4-byte-only instance exercised by hand-written
// sequences for alignment corner cases. Both instances share the inputs.
module tb_pc_unit;

  logic        clk;
  logic        rst, stall, trap, mret, redir, comp, call, ret;
  logic [31:0] tvec, mepc, raddr;

  logic [31:0] pc_c, seq_c, pc_n, seq_n;
  logic        mis_c, emp_c, full_c, mis_n, emp_n, full_n;

  int n_checks = 0;
  int n_fail   = 0;

  pc_unit #(.WIDTH_P(32), .RESET_ADDR_P(32'h100), .C_EXT_P(1), .RAS_DEPTH_P(4)) dut_c (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .trap_i(trap), .trap_vec_i(tvec),
    .mret_i(mret), .mepc_i(mepc), .redirect_i(redir), .redirect_addr_i(raddr),
    .compressed_i(comp), .call_i(call), .ret_i(ret),
    .pc_q_o(pc_c), .pc_seq_o(seq_c), .misalign_o(mis_c),
    .ras_empty_o(emp_c), .ras_full_o(full_c)
  );

  pc_unit #(.WIDTH_P(32), .RESET_ADDR_P(32'h100), .C_EXT_P(0), .RAS_DEPTH_P(4)) dut_n (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .trap_i(trap), .trap_vec_i(tvec),
    .mret_i(mret), .mepc_i(mepc), .redirect_i(redir), .redirect_addr_i(raddr),
    .compressed_i(comp), .call_i(call), .ret_i(ret),
    .pc_q_o(pc_n), .pc_seq_o(seq_n), .misalign_o(mis_n),
    .ras_empty_o(emp_n), .ras_full_o(full_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        rst, stall, trap;
    logic [31:0] tvec;
    logic        mret;
    logic [31:0] mepc;
    logic        redir;
    logic [31:0] raddr;
    logic        comp, call, ret;
    logic [31:0] eseq;
    logic        emis;
    logic [31:0] epc;
    logic        eemp, efull;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic s, input logic t, input logic [31:0] tv,
                              input logic m, input logic [31:0] me, input logic rd,
                              input logic [31:0] ra, input logic cp, input logic cl,
                              input logic rt, input logic [31:0] es, input logic em,
                              input logic [31:0] ep, input logic ee, input logic ef);
    vec_t v;
    v.rst = r; v.stall = s; v.trap = t; v.tvec = tv; v.mret = m; v.mepc = me;
    v.redir = rd; v.raddr = ra; v.comp = cp; v.call = cl; v.ret = rt;
    v.eseq = es; v.emis = em; v.epc = ep; v.eemp = ee; v.efull = ef;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; trap = 0; mret = 0; redir = 0; comp = 0; call = 0; ret = 0;
    tvec = 0; mepc = 0; raddr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset pc_c", pc_c, 32'h100);
    check("reset pc_n", pc_n, 32'h100);
    check("reset empty", {31'b0, emp_c}, 32'd1);
    check("reset full", {31'b0, full_c}, 32'd0);
    check("reset misalign", {31'b0, mis_c}, 32'd0);
    rst = 0;

    //  rst s t tvec      m mepc    rd raddr        c cl rt  eseq        mis epc          emp full
    add(0, 0,0,0,         0,0,      0,0,            0,0,0,   'h104,      0,  'h104,       1,0); // sequential
    add(0, 0,0,0,         0,0,      0,0,            1,0,0,   'h106,      0,  'h106,       1,0); // +2
    add(0, 0,0,0,         0,0,      0,0,            0,0,0,   'h10A,      0,  'h10A,       1,0);
    add(0, 0,0,0,         0,0,      1,'h200,        0,0,0,   'h10E,      0,  'h200,       1,0);
    add(0, 1,1,'h803,     1,'h500,  1,'h600,        0,0,0,   'h204,      0,  'h800,       1,0); // trap wins
    add(0, 0,0,0,         1,'h500,  1,'h600,        0,0,0,   'h804,      0,  'h500,       1,0); // mret wins
    add(0, 1,0,0,         0,0,      1,'h600,        0,0,0,   'h504,      0,  'h600,       1,0); // redirect over stall
    add(0, 1,0,0,         0,0,      0,0,            0,0,0,   'h604,      0,  'h600,       1,0); // stall holds
    add(0, 0,0,0,         1,'h503,  0,0,            0,0,0,   'h604,      0,  'h502,       1,0); // mret bit0 cleared
    add(0, 0,1,'h1001,    0,0,      1,'h601,        0,0,0,   'h506,      0,  'h1000,      1,0); // trap masks misalign
    add(0, 0,0,0,         0,0,      1,'h601,        0,0,0,   'h1004,     1,  'h1000,      1,0); // misaligned holds
    add(0, 0,0,0,         0,0,      0,0,            0,1,0,   'h1004,     0,  'h1004,      0,0); // call @1000
    add(0, 0,0,0,         0,0,      1,'h2000,       0,0,0,   'h1008,     0,  'h2000,      0,0);
    add(0, 0,0,0,         0,0,      0,0,            0,1,0,   'h2004,     0,  'h2004,      0,0); // call @2000
    add(0, 0,0,0,         0,0,      1,'h3000,       0,0,0,   'h2008,     0,  'h3000,      0,0);
    add(0, 0,0,0,         0,0,      0,0,            0,0,1,   'h3004,     0,  'h2004,      0,0); // ret
    add(0, 0,0,0,         0,0,      0,0,            0,0,1,   'h2008,     0,  'h1004,      1,0); // ret
    add(0, 0,0,0,         0,0,      0,0,            0,0,1,   'h1008,     0,  'h1008,      1,0); // ret on empty
    add(0, 0,0,0,         0,0,      0,0,            0,1,0,   'h100C,     0,  'h100C,      0,0); // A1
    add(0, 0,0,0,         0,0,      0,0,            0,1,0,   'h1010,     0,  'h1010,      0,0); // A2
    add(0, 0,0,0,         0,0,      0,0,            0,1,0,   'h1014,     0,  'h1014,      0,0); // A3
    add(0, 0,0,0,         0,0,      0,0,            0,1,0,   'h1018,     0,  'h1018,      0,1); // A4 full
    add(0, 0,0,0,         0,0,      0,0,            0,1,0,   'h101C,     0,  'h101C,      0,1); // A5 wraps
    add(0, 0,0,0,         0,0,      1,'h4000,       0,0,0,   'h1020,     0,  'h4000,      0,1);
    add(0, 0,0,0,         0,0,      0,0,            0,0,1,   'h4004,     0,  'h101C,      0,0); // A5
    add(0, 0,0,0,         0,0,      0,0,            0,0,1,   'h1020,     0,  'h1018,      0,0); // A4
    add(0, 0,0,0,         0,0,      0,0,            0,0,1,   'h101C,     0,  'h1014,      0,0); // A3
    add(0, 0,0,0,         0,0,      0,0,            0,0,1,   'h1018,     0,  'h1010,      1,0); // A2
    add(0, 0,0,0,         0,0,      0,0,            0,0,1,   'h1014,     0,  'h1014,      1,0); // sequential
    add(0, 1,0,0,         0,0,      0,0,            0,1,0,   'h1018,     0,  'h1014,      1,0); // call stalled
    add(0, 0,0,0,         0,0,      0,0,            0,1,0,   'h1018,     0,  'h1018,      0,0);
    add(0, 0,0,0,         0,0,      1,'h5000,       0,0,1,   'h101C,     0,  'h5000,      0,0); // ret suppressed
    add(0, 0,0,0,         0,0,      0,0,            1,1,1,   'h5002,     0,  'h1018,      0,0); // call+ret
    add(0, 0,0,0,         0,0,      0,0,            0,0,1,   'h101C,     0,  'h5002,      1,0); // overwritten top
    add(0, 0,0,0,         0,0,      0,0,            0,1,1,   'h5006,     0,  'h5006,      0,0); // call+ret empty
    add(0, 0,0,0,         0,0,      0,0,            0,1,0,   'h500A,     0,  'h500A,      0,0);
    add(1, 0,0,0,         0,0,      1,'h601,        0,1,0,   'h500E,     0,  'h100,       1,0); // reset mid-run
    add(0, 0,0,0,         0,0,      0,0,            0,0,1,   'h104,      0,  'h104,       1,0);
    add(0, 0,0,0,         0,0,      1,'hFFFF_FFFC,  0,0,0,   'h108,      0,  'hFFFF_FFFC, 1,0);
    add(0, 0,0,0,         0,0,      0,0,            0,0,0,   'h0,        0,  'h0,         1,0); // wrap

    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; stall = vq[i].stall; trap = vq[i].trap; tvec = vq[i].tvec;
      mret = vq[i].mret; mepc = vq[i].mepc; redir = vq[i].redir; raddr = vq[i].raddr;
      comp = vq[i].comp; call = vq[i].call; ret = vq[i].ret;
      #1;
      check($sformatf("row%0d pc_seq", i), seq_c, vq[i].eseq);
      check($sformatf("row%0d misalign", i), {31'b0, mis_c}, {31'b0, vq[i].emis});
      tick();
      check($sformatf("row%0d pc", i), pc_c, vq[i].epc);
      check($sformatf("row%0d empty", i), {31'b0, emp_c}, {31'b0, vq[i].eemp});
      check($sformatf("row%0d full", i), {31'b0, full_c}, {31'b0, vq[i].efull});
    end

    // Alignment corner cases against the 4-byte-only instance.
    idle_inputs();
    rst = 1;
    tick();
    check("n reset pc", pc_n, 32'h100);
    rst = 0; redir = 1; raddr = 32'h40;
    tick();
    check("n redirect 40", pc_n, 32'h40);
    raddr = 32'h302;
    #1;
    check("n misalign 302", {31'b0, mis_n}, 32'd1);
    check("c misalign 302", {31'b0, mis_c}, 32'd0);
    tick();
    check("n pc held", pc_n, 32'h40);
    check("c pc 302", pc_c, 32'h302);
    raddr = 32'h304;
    #1;
    check("n misalign 304", {31'b0, mis_n}, 32'd0);
    tick();
    check("n pc 304", pc_n, 32'h304);
    redir = 0; mret = 1; mepc = 32'h503;
    tick();
    check("n mret aligned", pc_n, 32'h500);
    check("c mret aligned", pc_c, 32'h502);
    mret = 0; comp = 1;
    #1;
    check("n step ignores compressed", seq_n, 32'h504);
    check("c step compressed", seq_c, 32'h504);
    tick();
    check("n pc after step", pc_n, 32'h504);
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
